// File: rtl/hmmm_pkg.sv
// Shared definitions for the Hmmm arithmetic unit: ALU op encodings,
// datapath defaults and the issue-controller state encoding.
package hmmm_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_RADDR_W = 4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_DIV = 3'b011;
  localparam logic [2:0] ALU_MOD = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    EXEC,
    WB
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= ALU_MOD;
  endfunction

  function automatic logic op_divides(input logic [2:0] op);
    return (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/hmmm_alu_ctrl.sv
// Issue-side controller for the Hmmm ALU: accepts one decoded instruction,
// reads its operands, sequences the ALU and writes the result back.
module hmmm_alu_ctrl
  import hmmm_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [RADDR_W-1:0] req_rd,
  input  logic [RADDR_W-1:0] req_rs1,
  input  logic [RADDR_W-1:0] req_rs2,
  input  logic               req_use_imm,
  input  logic [7:0]         req_imm,
  output logic [RADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0]  rf_rdata,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [DATA_W-1:0]  alu_tmp1,
  output logic [DATA_W-1:0]  alu_tmp2,
  output logic [2:0]         alu_op,
  output logic               alu_enable,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               alu_sign,
  output logic               done,
  output logic               flag_zero,
  output logic               flag_carry,
  output logic               flag_sign,
  output logic               err_div0,
  output logic               err_illegal
);

  state_t               state, state_nxt;
  logic [2:0]           op_q;
  logic [RADDR_W-1:0]   rd_q, rs1_q, rs2_q;
  logic                 use_imm_q;
  logic                 accept;
  logic                 div0;
  logic [DATA_W-1:0]    rd_value;

  assign accept   = req_valid & req_ready;
  assign div0     = op_divides(alu_op) && (alu_tmp2 == '0);
  // r0 is hardwired to zero whatever the register file returns
  assign rd_value = (rf_raddr == '0) ? '0 : rf_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    rf_raddr   = '0;
    alu_enable = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = op_legal(req_op) ? RD_A : WB;
      end
      RD_A: begin
        rf_raddr  = rs1_q;
        state_nxt = use_imm_q ? EXEC : RD_B;
      end
      RD_B: begin
        rf_raddr  = rs2_q;
        state_nxt = EXEC;
      end
      EXEC: begin
        alu_enable = !div0;
        state_nxt  = WB;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write-back strobes live for exactly the WB cycle; status is held between dones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      use_imm_q   <= 1'b0;
      alu_tmp1    <= '0;
      alu_tmp2    <= '0;
      alu_op      <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      done        <= 1'b0;
      flag_zero   <= 1'b0;
      flag_carry  <= 1'b0;
      flag_sign   <= 1'b0;
      err_div0    <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= req_op;
            rd_q      <= req_rd;
            rs1_q     <= req_rs1;
            rs2_q     <= req_rs2;
            use_imm_q <= req_use_imm;
            alu_tmp2  <= req_use_imm ? {{(DATA_W-8){req_imm[7]}}, req_imm} : '0;
            if (!op_legal(req_op)) begin
              done        <= 1'b1;
              flag_zero   <= 1'b0;
              flag_carry  <= 1'b0;
              flag_sign   <= 1'b0;
              err_div0    <= 1'b0;
              err_illegal <= 1'b1;
            end
          end
        end
        RD_A: begin
          alu_tmp1 <= rd_value;
          if (use_imm_q) alu_op <= op_q;
        end
        RD_B: begin
          alu_tmp2 <= rd_value;
          alu_op   <= op_q;
        end
        EXEC: begin
          done        <= 1'b1;
          rf_we       <= (rd_q != '0);
          rf_waddr    <= rd_q;
          err_illegal <= 1'b0;
          // A zero divisor never reaches the ALU; the result is forced to zero
          if (div0) begin
            rf_wdata   <= '0;
            flag_zero  <= 1'b1;
            flag_carry <= 1'b0;
            flag_sign  <= 1'b0;
            err_div0   <= 1'b1;
          end else begin
            rf_wdata   <= alu_result;
            flag_zero  <= alu_zero;
            flag_carry <= alu_carry;
            flag_sign  <= alu_sign;
            err_div0   <= 1'b0;
          end
        end
        WB: begin
          alu_tmp1 <= '0;
          alu_tmp2 <= '0;
          alu_op   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hmmm_alu_ctrl.sv
// Scoreboard bench for hmmm_alu_ctrl: a behavioural register file and ALU
// surround the controller, and expected write-backs come from a reference model.
module tb_hmmm_alu_ctrl;
  import hmmm_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_rd, req_rs1, req_rs2;
  logic          req_use_imm;
  logic [7:0]    req_imm;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] alu_tmp1, alu_tmp2;
  logic [2:0]    alu_op;
  logic          alu_enable;
  logic [DW-1:0] alu_result;
  logic          alu_zero, alu_carry, alu_sign;
  logic          done, flag_zero, flag_carry, flag_sign, err_div0, err_illegal;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        z, c, s, dz, il;
    bit          enable;
    bit          checkData;
    int          doneCycle;
  } exp_t;

  exp_t          expQ[$];
  exp_t          monE;
  int            checks = 0;
  int            failures = 0;
  int            cycleCount = 0;
  logic [DW-1:0] rf[16];
  logic [DW-1:0] refRf[16];
  logic          bdWe = 1'b0;
  logic [AW-1:0] bdAddr = '0;
  logic [DW-1:0] bdData = '0;
  bit            sawEnable = 0;
  logic [4:0]    heldStatus = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  always @(posedge clk) begin
    if (bdWe) rf[bdAddr] <= bdData;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  assign rf_rdata = rf[rf_raddr];

  hmmm_alu_ctrl #(.DATA_W(DW), .RADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_use_imm(req_use_imm), .req_imm(req_imm),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_tmp1(alu_tmp1), .alu_tmp2(alu_tmp2), .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign),
    .done(done), .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_sign(flag_sign),
    .err_div0(err_div0), .err_illegal(err_illegal)
  );

  // Signed Hmmm arithmetic on plain integers; returns {sign, carry, zero, result}
  function automatic logic [18:0] aluRef(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    int          sa, sb, full;
    logic [15:0] res;
    logic        c;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      ALU_ADD: full = sa + sb;
      ALU_SUB: full = sa - sb;
      ALU_MUL: full = sa * sb;
      ALU_DIV: full = (sb == 0) ? 0 : sa / sb;
      ALU_MOD: full = (sb == 0) ? 0 : sa % sb;
      default: full = 0;
    endcase
    res = full[15:0];
    c   = (op != ALU_MOD) && (full > 32767 || full < -32768);
    return {res[15], c, (res == 16'h0000), res};
  endfunction

  // Disabled ALU drives junk so that any use of it while disabled shows up
  always_comb begin
    if (alu_enable) {alu_sign, alu_carry, alu_zero, alu_result} = aluRef(alu_op, alu_tmp1, alu_tmp2);
    else            {alu_sign, alu_carry, alu_zero, alu_result} = {1'b1, 1'b1, 1'b0, 16'hDEAD};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      sawEnable  = 0;
      heldStatus = '0;
    end else begin
      if (alu_enable) begin
        sawEnable = 1;
        if (expQ.size() == 0) checkOutput("enable_without_request", 32'(alu_enable), 32'd0);
        else begin
          checkOutput("alu_tmp1", 32'(alu_tmp1), 32'(expQ[0].a));
          checkOutput("alu_tmp2", 32'(alu_tmp2), 32'(expQ[0].b));
          checkOutput("alu_op", 32'(alu_op), 32'(expQ[0].op));
        end
      end
      if (rf_we && !done) checkOutput("we_without_done", 32'(rf_we), 32'(done));
      if (!done && {flag_zero, flag_carry, flag_sign, err_div0, err_illegal} !== heldStatus)
        checkOutput("status_held", 32'({flag_zero, flag_carry, flag_sign, err_div0, err_illegal}),
                    32'(heldStatus));
      if (done) begin
        if (expQ.size() == 0) checkOutput("unexpected_done", 32'(done), 32'd0);
        else begin
          monE = expQ.pop_front();
          checkOutput("done_cycle", 32'(cycleCount), 32'(monE.doneCycle));
          checkOutput("rf_we", 32'(rf_we), 32'(monE.we));
          if (monE.we) checkOutput("rf_waddr", 32'(rf_waddr), 32'(monE.waddr));
          if (monE.checkData) checkOutput("rf_wdata", 32'(rf_wdata), 32'(monE.wdata));
          checkOutput("flags_zcs", 32'({flag_zero, flag_carry, flag_sign}),
                      32'({monE.z, monE.c, monE.s}));
          checkOutput("errors_div0_ill", 32'({err_div0, err_illegal}), 32'({monE.dz, monE.il}));
          checkOutput("alu_enable_seen", 32'(sawEnable), 32'(monE.enable));
        end
        sawEnable  = 0;
        heldStatus = {flag_zero, flag_carry, flag_sign, err_div0, err_illegal};
      end
    end
  end

  task automatic setReg(input int idx, input logic [15:0] val);
    @(posedge clk); #1;
    bdWe   = 1'b1;
    bdAddr = 4'(idx);
    bdData = val;
    @(posedge clk); #1;
    bdWe       = 1'b0;
    refRf[idx] = val;
  endtask

  task automatic drainQueue();
    int n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                               input logic [3:0] rs2, input logic useImm, input logic [7:0] imm,
                               input bit track);
    exp_t        e;
    logic [15:0] a, b;
    int          lat;
    int          waitCycles;
    a = (rs1 == 4'd0) ? 16'h0000 : refRf[rs1];
    b = useImm ? {{8{imm[7]}}, imm} : ((rs2 == 4'd0) ? 16'h0000 : refRf[rs2]);
    e.op = op; e.a = a; e.b = b;
    e.dz = 1'b0; e.il = 1'b0; e.enable = 0; e.checkData = 1;
    e.z = 1'b0; e.c = 1'b0; e.s = 1'b0; e.wdata = 16'h0000;
    if (op > ALU_MOD) begin
      lat = 1; e.il = 1'b1; e.we = 1'b0; e.waddr = 4'd0; e.checkData = 0;
    end else begin
      lat = useImm ? 3 : 4;
      e.we = (rd != 4'd0);
      e.waddr = rd;
      if ((op == ALU_DIV || op == ALU_MOD) && b == 16'h0000) begin
        e.dz = 1'b1; e.z = 1'b1;
      end else begin
        {e.s, e.c, e.z, e.wdata} = aluRef(op, a, b);
        e.enable = 1;
      end
    end
    @(posedge clk); #1;
    waitCycles = 0;
    while (!req_ready && waitCycles < 50) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (!req_ready) begin
      checkOutput("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    req_use_imm = useImm; req_imm = imm;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 3'($urandom); req_rd = 4'($urandom); req_rs1 = 4'($urandom);
    req_rs2 = 4'($urandom); req_use_imm = 1'($urandom); req_imm = 8'($urandom);
    e.doneCycle = cycleCount + lat - 1;
    if (track) begin
      expQ.push_back(e);
      if (e.we) refRf[rd] = e.wdata;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_rf_port"}, 32'({rf_raddr, rf_we, rf_waddr}), 32'd0);
    checkOutput({tag, "_rf_wdata"}, 32'(rf_wdata), 32'd0);
    checkOutput({tag, "_alu_tmp"}, {alu_tmp1, alu_tmp2}, 32'd0);
    checkOutput({tag, "_alu_ctl_done"}, 32'({alu_op, alu_enable, done}), 32'd0);
    checkOutput({tag, "_status"},
                32'({flag_zero, flag_carry, flag_sign, err_div0, err_illegal}), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    logic [2:0] op;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
    req_use_imm = 1'b0; req_imm = '0;
    for (int i = 0; i < 16; i++)
      setReg(i, (i == 0) ? 16'h1234 : ((i == 5 || i == 9) ? 16'h0000 : 16'($urandom)));
    #1;
    checkResetState("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    setReg(1, 16'd5); setReg(2, 16'd7);
    applyStimulus(ALU_ADD, 4'd3, 4'd1, 4'd2, 1'b0, 8'h00, 1);
    drainQueue();
    setReg(1, 16'd3); setReg(2, 16'd3);
    applyStimulus(ALU_SUB, 4'd4, 4'd1, 4'd2, 1'b0, 8'h00, 1);
    drainQueue();
    setReg(2, 16'd7);
    applyStimulus(ALU_SUB, 4'd4, 4'd0, 4'd2, 1'b0, 8'h00, 1);
    drainQueue();
    setReg(1, 16'h7FFF);
    applyStimulus(ALU_ADD, 4'd5, 4'd1, 4'd0, 1'b1, 8'h01, 1);
    drainQueue();
    setReg(1, 16'd10); setReg(2, 16'd0);
    applyStimulus(ALU_DIV, 4'd6, 4'd1, 4'd2, 1'b0, 8'h00, 1);
    drainQueue();
    setReg(2, 16'd3);
    applyStimulus(ALU_MOD, 4'd6, 4'd1, 4'd2, 1'b0, 8'h00, 1);
    applyStimulus(ALU_ADD, 4'd0, 4'd1, 4'd2, 1'b0, 8'h00, 1);
    applyStimulus(3'b110, 4'd3, 4'd1, 4'd2, 1'b0, 8'h00, 1);
    drainQueue();

    // Abort an instruction in EXEC with an asynchronous reset
    setReg(1, 16'd5); setReg(2, 16'd7);
    applyStimulus(ALU_ADD, 4'd7, 4'd1, 4'd2, 1'b0, 8'h00, 0);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("exec_before_reset", 32'(alu_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    checkResetState("midreset");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    applyStimulus(ALU_ADD, 4'd8, 4'd1, 4'd2, 1'b0, 8'h00, 1);
    drainQueue();

    for (int i = 0; i < 80; i++) begin
      if (i % 10 == 9) begin
        drainQueue();
        setReg(int'($urandom_range(1, 15)),
               ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
      end
      r  = int'($urandom_range(0, 15));
      op = (r < 13) ? 3'(r % 5) : 3'(r - 8);
      applyStimulus(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0),
                    8'($urandom), 1);
    end
    drainQueue();

    for (int i = 1; i < 16; i++) checkOutput($sformatf("rf_final_r%0d", i), 32'(rf[i]), 32'(refRf[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
